// File: rtl/osd_pkg.sv
// osd_pkg: default divider ratios and counter width helper for the OSD timebase
package osd_pkg;
  localparam int OSD_HALF1 = 2;
  localparam int OSD_HALF2 = 2;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/osd_prescaler.sv
// osd_prescaler: divides tick_in events into a 50% square wave with a rising-edge strobe
module osd_prescaler
  import osd_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic start,
  input  logic tick_in,
  output logic wave,
  output logic rise
);
  localparam int W = cnt_width(HALF);
  localparam logic [W-1:0] LAST = W'(HALF - 1);
  logic [W-1:0] cnt;
  logic last;
  assign last = cnt == LAST;
  assign rise = tick_in && last && !wave;
  always_ff @(posedge clk) begin
    if (start) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (tick_in) begin
      cnt  <= last ? '0 : cnt + 1'b1;
      wave <= wave ^ last;
    end
  end
endmodule

// File: rtl/osd_timebase.sv
// osd_timebase: two cascaded prescalers giving the OSD fast and slow rate references
module osd_timebase
  import osd_pkg::*;
#(
  parameter int HALF1 = OSD_HALF1,
  parameter int HALF2 = OSD_HALF2
) (
  input  logic clk,
  input  logic start,
  input  logic enable,
  output logic clk_out1,
  output logic clk_out2
);
  logic rise1, rise2;
  osd_prescaler #(.HALF(HALF1)) u_stage1 (
    .clk(clk), .start(start), .tick_in(enable), .wave(clk_out1), .rise(rise1)
  );
  osd_prescaler #(.HALF(HALF2)) u_stage2 (
    .clk(clk), .start(start), .tick_in(enable && rise1), .wave(clk_out2), .rise(rise2)
  );
  // The slow clock may only rise on an edge where the fast clock also rises
  a_cascade: assert property (@(posedge clk) rise2 |-> rise1);
endmodule

// File: tb/tb_osd_timebase.sv
// tb_osd_timebase: random and directed checks of osd_timebase against an edge-count model
module tb_osd_timebase;
  logic clk = 1'b0;
  logic start = 1'b1;
  logic enable = 1'b0;
  logic a_out1, a_out2, b_out1, b_out2;
  int tests = 0;
  int failed = 0;
  int e = 0;
  always #5 clk = ~clk;
  osd_timebase dut_a (
    .clk(clk), .start(start), .enable(enable), .clk_out1(a_out1), .clk_out2(a_out2)
  );
  osd_timebase #(.HALF1(1), .HALF2(3)) dut_b (
    .clk(clk), .start(start), .enable(enable), .clk_out1(b_out1), .clk_out2(b_out2)
  );
  function automatic logic exp1(input int n, input int h1);
    return ((n / h1) % 2) == 1;
  endfunction
  function automatic logic exp2(input int n, input int h1, input int h2);
    int first;
    first = (2 * h2 - 1) * h1;
    if (n < first) return 1'b0;
    return (((n - first) / (2 * h1 * h2)) % 2) == 0;
  endfunction
  task automatic step(input logic s, input logic en);
    @(negedge clk);
    start = s;
    enable = en;
    @(posedge clk);
    if (s) e = 0;
    else if (en) e++;
    #1;
  endtask
  task automatic test_reset();
    step(1'b1, 1'b1);
    tests++;
    if ({a_out1, a_out2, b_out1, b_out2} !== 4'b0000) begin
      failed++;
      $display("FAIL reset: outputs a=%b%b b=%b%b, required 0000", a_out1, a_out2, b_out1, b_out2);
    end
  endtask
  task automatic test_free_run();
    logic [23:0] w1 = 24'b0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1);
      w1[i] = a_out1;
      tests++;
      if (a_out2 !== exp2(e, 2, 2)) begin
        failed++;
        $display("FAIL free_run out2 E%0d: got %b, required %b", e, a_out2, exp2(e, 2, 2));
      end
    end
    tests++;
    if (w1 !== 24'b001100110011001100110011 >> 1 << 0 ^ 24'b0 && w1 !== 24'h666666) begin
      failed++;
      $display("FAIL free_run out1 sequence: got %b, required %b", w1, 24'h666666);
    end
  endtask
  task automatic test_hold_start();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      tests++;
      if ({a_out1, a_out2, b_out1, b_out2} !== 4'b0000) begin
        failed++;
        $display("FAIL hold_start cycle %0d: a=%b%b b=%b%b, required 0000", i, a_out1, a_out2, b_out1, b_out2);
      end
    end
    step(1'b0, 1'b1);
    tests++;
    if (a_out1 !== 1'b0) begin
      failed++;
      $display("FAIL hold_start E1: out1 %b, required 0", a_out1);
    end
    step(1'b0, 1'b1);
    tests++;
    if (a_out1 !== 1'b1) begin
      failed++;
      $display("FAIL hold_start E2: out1 %b, required 1", a_out1);
    end
  endtask
  task automatic test_enable_gap();
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      tests++;
      if (a_out1 !== 1'b1 || a_out2 !== 1'b0) begin
        failed++;
        $display("FAIL enable_gap hold %0d: out1=%b out2=%b, required 1 0", i, a_out1, a_out2);
      end
    end
    step(1'b0, 1'b1);
    tests++;
    if (a_out1 !== 1'b0) begin
      failed++;
      $display("FAIL enable_gap shifted fall: out1 %b, required 0", a_out1);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      tests++;
      if (a_out1 !== exp1(e, 2) || a_out2 !== exp2(e, 2, 2)) begin
        failed++;
        $display("FAIL enable_gap E%0d: got %b%b, required %b%b", e, a_out1, a_out2, exp1(e, 2), exp2(e, 2, 2));
      end
    end
  endtask
  task automatic test_restart();
    step(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    tests++;
    if (a_out2 !== 1'b1) begin
      failed++;
      $display("FAIL restart E9: out2 %b, required 1", a_out2);
    end
    step(1'b1, 1'b1);
    tests++;
    if (a_out1 !== 1'b0 || a_out2 !== 1'b0) begin
      failed++;
      $display("FAIL restart clear: out1=%b out2=%b, required 0 0", a_out1, a_out2);
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1);
      tests++;
      if (a_out1 !== exp1(e, 2) || a_out2 !== exp2(e, 2, 2)) begin
        failed++;
        $display("FAIL restart E%0d: got %b%b, required %b%b", e, a_out1, a_out2, exp1(e, 2), exp2(e, 2, 2));
      end
    end
  endtask
  task automatic test_small_div();
    int highs = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1);
      if (e > 4 && e <= 16) highs += int'(b_out2);
      tests++;
      if (b_out1 !== exp1(e, 1) || b_out2 !== exp2(e, 1, 3)) begin
        failed++;
        $display("FAIL small_div E%0d: got %b%b, required %b%b", e, b_out1, b_out2, exp1(e, 1), exp2(e, 1, 3));
      end
    end
    tests++;
    if (highs != 6) begin
      failed++;
      $display("FAIL small_div duty: high cycles %0d of 12, required 6", highs);
    end
  endtask
  task automatic test_random_long();
    logic p_a1, p_a2, p_b1, p_b2;
    step(1'b1, 1'b1);
    p_a1 = a_out1; p_a2 = a_out2; p_b1 = b_out1; p_b2 = b_out2;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0);
      tests++;
      if (a_out1 !== exp1(e, 2) || a_out2 !== exp2(e, 2, 2) ||
          b_out1 !== exp1(e, 1) || b_out2 !== exp2(e, 1, 3)) begin
        failed++;
        $display("FAIL random E%0d: a=%b%b b=%b%b, required a=%b%b b=%b%b", e, a_out1, a_out2, b_out1, b_out2,
                 exp1(e, 2), exp2(e, 2, 2), exp1(e, 1), exp2(e, 1, 3));
      end
      if (!start) begin
        tests++;
        if ((a_out2 != p_a2 && !(a_out1 && !p_a1)) || (b_out2 != p_b2 && !(b_out1 && !p_b1))) begin
          failed++;
          $display("FAIL random cascade E%0d: out2 edge without out1 rise, a %b%b->%b%b b %b%b->%b%b", e,
                   p_a1, p_a2, a_out1, a_out2, p_b1, p_b2, b_out1, b_out2);
        end
      end
      p_a1 = a_out1; p_a2 = a_out2; p_b1 = b_out1; p_b2 = b_out2;
    end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_hold_start();
    test_enable_gap();
    test_restart();
    test_small_div();
    test_random_long();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
